bcd2bin: RTL and testbench

BCD2BIN -- requirements
Module: bcd2bin

---
 rtl/bcd2bin_pkg.sv | 30 +++
 rtl/bcd_digit_corr.sv | 15 +
 rtl/bcd2bin.sv | 178 +++++++++++++++++
 tb/tb_bcd2bin.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bcd2bin_pkg.sv
// rtl/bcd2bin_pkg.sv - shared types and constants for the BCD-to-binary converter
//
// Purpose : state encoding, datapath widths, shift count and a digit validity helper.
// Config  : BCD2BIN_SERIAL_EN adds the ST_TX state used by the serial transmit phase.
package bcd2bin_pkg;

    localparam int BCD_W     = 8;
    localparam int BIN_W     = 7;
    localparam int WORK_W    = BCD_W + BIN_W;
    localparam int SHIFT_CNT = 7;

    // Last counter value of a 7-step phase (counter runs 0..6).
    localparam logic [2:0] CNT_LAST = 3'(SHIFT_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
`ifdef BCD2BIN_SERIAL_EN
        ,
        ST_TX    = 2'd3
`endif
    } state_e;

    // Both BCD digits must lie in 0..9 for the operand to be accepted.
    function automatic logic bcd_valid(input logic [BCD_W-1:0] bcd);
        return (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// rtl/bcd_digit_corr.sv - reverse double-dabble digit correction
//
// Purpose : combinational correction of one BCD digit after a right shift.
//           A digit that reached 8 or more carried a half-weight of 5 from the
//           digit above; subtracting 3 restores a valid BCD value.
// Ports   : digit_i  [3:0]  digit after shift
//           digit_o  [3:0]  corrected digit (digit_i - 3 when digit_i >= 8)
module bcd_digit_corr (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd8) ? (digit_i - 4'd3) : digit_i;

endmodule

// File: rtl/bcd2bin.sv
// rtl/bcd2bin.sv - sequential two-digit BCD to 7-bit binary converter
//
// Purpose : converts a two-digit BCD operand to binary by 7 steps of reverse
//           double-dabble on a 15-bit work register {bcd[7:0], bin[6:0]}.
//           Optional serial transmit of the result when BCD2BIN_SERIAL_EN is defined.
// Ports   : clk        system clock, rising edge
//           rst        synchronous active-high reset
//           load       start request (ignored while busy)
//           num_bcd    [7:4] tens digit, [3:0] units digit
//           num_bin    registered binary result, held until the next completion
//           busy       conversion or serial transmit in progress
//           done       one-cycle pulse when num_bin is updated
//           err        one-cycle pulse when a load carries a digit >= 10
//           ser_out    result bit, LSB first     (BCD2BIN_SERIAL_EN only)
//           ser_valid  ser_out qualifier         (BCD2BIN_SERIAL_EN only)
module bcd2bin
    import bcd2bin_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BCD_W-1:0] num_bcd,
    output logic [BIN_W-1:0] num_bin,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef BCD2BIN_SERIAL_EN
    ,
    output logic             ser_out,
    output logic             ser_valid
`endif
);

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [BIN_W-1:0]    num_bin_q, num_bin_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
`ifdef BCD2BIN_SERIAL_EN
    logic                ser_out_q, ser_out_d;
    logic                ser_valid_q, ser_valid_d;
`endif

    // One reverse double-dabble step: shift right, then correct each digit.
    logic [WORK_W-1:0]   work_shr;
    logic [3:0]          tens_corr;
    logic [3:0]          units_corr;
    logic [WORK_W-1:0]   work_step;

    assign work_shr = work_q >> 1;

    bcd_digit_corr u_tens_corr (
        .digit_i (work_shr[14:11]),
        .digit_o (tens_corr)
    );

    bcd_digit_corr u_units_corr (
        .digit_i (work_shr[10:7]),
        .digit_o (units_corr)
    );

    assign work_step = {tens_corr, units_corr, work_shr[BIN_W-1:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        num_bin_d   = num_bin_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
`ifdef BCD2BIN_SERIAL_EN
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                // busy_q can still be high here for the final serial bit.
                if (load && !busy_q) begin
                    if (bcd_valid(num_bcd)) begin
                        work_d  = {num_bcd, {BIN_W{1'b0}}};
                        cnt_d   = 3'd0;
                        state_d = ST_SHIFT;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end

            ST_SHIFT: begin
                work_d = work_step;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 3'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = 3'(cnt_q + 3'd1);
                end
            end

            ST_DONE: begin
                num_bin_d = work_q[BIN_W-1:0];
                done_d    = 1'b1;
                cnt_d     = 3'd0;
`ifdef BCD2BIN_SERIAL_EN
                state_d   = ST_TX;
`else
                state_d   = ST_IDLE;
`endif
            end

`ifdef BCD2BIN_SERIAL_EN
            ST_TX: begin
                ser_out_d   = num_bin_q[cnt_q];
                ser_valid_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 3'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = 3'(cnt_q + 3'd1);
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase

        // Registered busy follows the next state so it is valid in the same
        // cycle as the state it describes; the last serial bit keeps it high.
`ifdef BCD2BIN_SERIAL_EN
        busy_d = (state_d != ST_IDLE) || ser_valid_d;
`else
        busy_d = (state_d != ST_IDLE);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            work_q      <= '0;
            num_bin_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef BCD2BIN_SERIAL_EN
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            num_bin_q   <= num_bin_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef BCD2BIN_SERIAL_EN
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
`endif
        end
    end

    assign num_bin   = num_bin_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
`ifdef BCD2BIN_SERIAL_EN
    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
`endif

endmodule

// File: tb/tb_bcd2bin.sv
// tb/tb_bcd2bin.sv - self-checking bench for bcd2bin
module tb_bcd2bin;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] num_bcd;
    logic [6:0] num_bin;
    logic       busy;
    logic       done;
    logic       err;
`ifdef BCD2BIN_SERIAL_EN
    logic       ser_out;
    logic       ser_valid;
`endif

    int n_checks = 0;
    int n_errors = 0;

    bcd2bin dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .num_bcd   (num_bcd),
        .num_bin   (num_bin),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef BCD2BIN_SERIAL_EN
        ,
        .ser_out   (ser_out),
        .ser_valid (ser_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bcd;
        logic [6:0] exp_bin;
        logic       exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive a one-cycle load; returns just after the sampling edge N (at negedge).
    task automatic start_load(input logic [7:0] b);
        @(negedge clk);
        load    = 1'b1;
        num_bcd = b;
        @(negedge clk);
        load    = 1'b0;
    endtask

    // Called after edge N; follows edges N+1..N+9, expecting done only at N+8.
    task automatic expect_conv(input logic [6:0] exp, input string nm);
        int early_done;
        early_done = 0;
        chk({nm, " busy@N"}, int'(busy), 1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k < 8 && done) early_done++;
        end
        chk({nm, " early done"}, early_done, 0);
        chk({nm, " done@N+8"}, int'(done), 1);
        chk({nm, " num_bin"}, int'(num_bin), int'(exp));
        chk({nm, " err"}, int'(err), 0);
`ifndef BCD2BIN_SERIAL_EN
        chk({nm, " busy@N+8"}, int'(busy), 0);
        @(negedge clk);
        chk({nm, " done@N+9"}, int'(done), 0);
`else
        for (int k = 9; k <= 15; k++) begin
            @(negedge clk);
            chk({nm, " ser_valid"}, int'(ser_valid), 1);
            chk({nm, " ser_out"}, int'(ser_out), int'(exp[k-9]));
        end
        @(negedge clk);
        @(negedge clk);
        chk({nm, " ser tail busy"}, int'(busy), 0);
        chk({nm, " ser tail valid"}, int'(ser_valid), 0);
`endif
    endtask

    // Idle for n cycles and count done pulses.
    task automatic quiet(input int n, input string nm);
        int pulses;
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk({nm, " stray done"}, pulses, 0);
    endtask

    initial begin
        logic [6:0] prev;

        vecs[0]  = '{8'h25, 7'd25, 1'b0};
        vecs[1]  = '{8'h99, 7'd99, 1'b0};
        vecs[2]  = '{8'h00, 7'd0,  1'b0};
        vecs[3]  = '{8'h3A, 7'd0,  1'b1};
        vecs[4]  = '{8'h47, 7'd47, 1'b0};
        vecs[5]  = '{8'hA0, 7'd47, 1'b1};
        vecs[6]  = '{8'h58, 7'd58, 1'b0};
        vecs[7]  = '{8'h10, 7'd10, 1'b0};
        vecs[8]  = '{8'h09, 7'd9,  1'b0};
        vecs[9]  = '{8'h9F, 7'd9,  1'b1};
        vecs[10] = '{8'h50, 7'd50, 1'b0};
        vecs[11] = '{8'h31, 7'd31, 1'b0};

        rst     = 1'b1;
        load    = 1'b0;
        num_bcd = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset num_bin", int'(num_bin), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset err", int'(err), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            start_load(vecs[i].bcd);
            if (vecs[i].exp_err) begin
                chk($sformatf("v%0d err", i), int'(err), 1);
                chk($sformatf("v%0d err busy", i), int'(busy), 0);
                chk($sformatf("v%0d err keep", i), int'(num_bin), int'(vecs[i].exp_bin));
                @(negedge clk);
                chk($sformatf("v%0d err pulse", i), int'(err), 0);
                chk($sformatf("v%0d err idle", i), int'(busy), 0);
            end else begin
                chk($sformatf("v%0d no err", i), int'(err), 0);
                expect_conv(vecs[i].exp_bin, $sformatf("v%0d", i));
            end
            @(negedge clk);
        end

        // Second load while busy is ignored.
        start_load(8'h47);
        @(negedge clk);
        @(negedge clk);
        load    = 1'b1;
        num_bcd = 8'h12;
        @(negedge clk);
        load    = 1'b0;
        chk("busy load no err", int'(err), 0);
        chk("busy load busy", int'(busy), 1);
        begin
            int early;
            early = 0;
            for (int k = 4; k <= 8; k++) begin
                @(negedge clk);
                if (k < 8 && done) early++;
            end
            chk("busy load early done", early, 0);
            chk("busy load done", int'(done), 1);
            chk("busy load num_bin", int'(num_bin), 47);
        end
        quiet(20, "busy load");
        chk("busy load keep", int'(num_bin), 47);

        // Reset mid-conversion aborts without done.
        prev = num_bin;
        chk("pre-reset nonzero", int'(prev != 7'd0), 1);
        start_load(8'h58);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort num_bin", int'(num_bin), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort err", int'(err), 0);
        quiet(12, "abort");
        start_load(8'h58);
        expect_conv(7'd58, "reload");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
